decode_unit: RTL and testbench
==============================

Name: decode_unit

Overview:
- Second pipeline stage of the Risky core. Sits directly downstream of the fetch stage and consumes its registered instruction.
- Splits the instruction into control and operand fields and registers them for the execute stage.
- Detects load-use hazards and the HALT instruction.
- Drives the combined halt_or_stall signal back to fetch, which freezes the PC and the instruction register.

Parameters:
- INSTRUCTION_SIZE, 16, instruction width. Field positions below assume 16.
- REG_ADDR_SIZE, 3, register index width (8 registers).
- IMM_SIZE, 8, immediate width.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- instruction_in  in  INSTRUCTION_SIZE  from fetch stage output. 16'h0000 = NOP.
- stall_in  in  1  downstream stall (e.g. memory busy). Freezes this stage and fetch.
- halt_or_stall  out  1  combinational, to fetch. Equals halted | hazard | stall_in.
- halted  out  1  registered, sticky halt flag.
- opcode_out  out  4  registered opcode.
- dest_out  out  REG_ADDR_SIZE  registered destination register.
- src1_out  out  REG_ADDR_SIZE  registered source 1.
- src2_out  out  REG_ADDR_SIZE  registered source 2.
- imm_out  out  IMM_SIZE  registered immediate.
- reg_write_out  out  1  registered; instruction writes dest.
- mem_read_out  out  1  registered; instruction is LOAD.
- mem_write_out  out  1  registered; instruction is STORE.

Behaviour:
- Field extraction: opcode=[15:12], dest=[11:9], src1=[8:6], src2=[5:3], imm=[7:0]. Fields are always extracted as-is, even where unused.
- Opcode classes:
  - 0x0 NOP: reads none, writes none.
  - 0x1-0x7 ALU: reads src1 and src2; reg_write=1.
  - 0x8 LOAD: reads src1; reg_write=1; mem_read=1.
  - 0x9 STORE: reads src1 and src2; mem_write=1.
  - 0xA LOADC: reads none; reg_write=1.
  - 0xB-0xE reserved: decoded as NOP (all output fields 0).
  - 0xF HALT.
- Bubble: every registered output = 0. This is the reset value of every registered output, including halted=0.
- Hazard (combinational): high when all of the following hold:
  - state is RUN,
  - the registered stage outputs hold a LOAD (mem_read_out=1),
  - the current instruction reads a register equal to dest_out.
  - A source field compares only if that instruction class actually reads it.
- State machine, states RUN and HALTED; reset enters RUN.
- Per rising edge, in priority order:
  1. stall_in=1: all registers and state hold. halt_or_stall=1.
  2. State HALTED: outputs are bubbles; halted=1. Exit only through reset.
  3. hazard=1: outputs load a bubble; fetch holds the same instruction. Next cycle mem_read_out=0, so the hazard clears and the instruction decodes normally. Exactly one stall cycle per load-use pair.
  4. instruction_in is HALT: outputs load a bubble; state goes to HALTED; halted=1 from the next cycle.
  5. Otherwise: outputs load the decoded fields; latency is 1 cycle.
- halt_or_stall is high in the same cycle the hazard or stall_in is present, and from the cycle after HALT is accepted.
- The HALT instruction itself does not assert halt_or_stall in its decode cycle.
- Reset mid-operation (any state, including during a stall): asynchronously clears all outputs and returns to RUN.
- LOAD followed by LOADC to the same register: no hazard, since LOADC reads nothing.
- Writes to register 0 get no special treatment.

Test Plan:
- Reset sequence: reset=0 with instruction_in=16'h1252 → all outputs 0, halt_or_stall=0. After reset rises, the next edge gives opcode_out=1, dest_out=1, src1_out=1, src2_out=2, reg_write_out=1.
- Load-use hazard:
  - LOAD 16'h8200 (dest=1, src1=0) then ALU 16'h1440 (src1=1).
  - Expected: the cycle after LOAD decodes, hazard=1 and halt_or_stall=1; the next edge produces a bubble.
  - Then the ALU instruction decodes with opcode_out=1 and halt_or_stall=0.
- No false hazard: LOAD dest=1, then LOADC 16'hA2FF (dest=1) → no stall, imm_out=8'hFF, reg_write_out=1.
- HALT: 16'hF000 → next edge halted=1 and halt_or_stall=1. Any later instruction, e.g. 16'h1252, leaves outputs at 0. Reset clears halted=0.
- stall_in:
  - Assert stall_in for 3 cycles while opcode_out=0x9 → outputs hold, halt_or_stall=1.
  - Deassert → the next instruction decodes on the following edge.
  - Also assert stall_in together with a pending hazard → hold; once stall_in drops, exactly one bubble is inserted.
- Reserved opcode 16'hC123 → all outputs 0. No hazard is raised, even after a LOAD to a matching register.

Source files
------------

// File: rtl/decode_unit.sv
// Decode stage of the Risky core.
// Splits the fetched instruction into registered control and operand fields
// for execute. It also detects load-use hazards and the sticky HALT condition,
// and drives halt_or_stall back to fetch.
//
// Handshake with fetch: when halt_or_stall is high at a rising edge, fetch
// must present the same instruction again on the next cycle. When it is low,
// the instruction on instruction_in is consumed at that edge.
module decode_unit #(
    parameter int INSTRUCTION_SIZE = 16,
    parameter int REG_ADDR_SIZE    = 3,
    parameter int IMM_SIZE         = 8
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [INSTRUCTION_SIZE-1:0] instruction_in,
    input  logic                        stall_in,
    output logic                        halt_or_stall,
    output logic                        halted,
    output logic [3:0]                  opcode_out,
    output logic [REG_ADDR_SIZE-1:0]    dest_out,
    output logic [REG_ADDR_SIZE-1:0]    src1_out,
    output logic [REG_ADDR_SIZE-1:0]    src2_out,
    output logic [IMM_SIZE-1:0]         imm_out,
    output logic                        reg_write_out,
    output logic                        mem_read_out,
    output logic                        mem_write_out
);

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_LOAD  = 4'h8;
    localparam logic [3:0] OP_STORE = 4'h9;
    localparam logic [3:0] OP_LOADC = 4'hA;
    localparam logic [3:0] OP_HALT  = 4'hF;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Raw instruction fields; always extracted, even when a class ignores them.
    logic [3:0]               w_opcode;
    logic [REG_ADDR_SIZE-1:0] w_dest;
    logic [REG_ADDR_SIZE-1:0] w_src1;
    logic [REG_ADDR_SIZE-1:0] w_src2;
    logic [IMM_SIZE-1:0]      w_imm;

    assign w_opcode = instruction_in[INSTRUCTION_SIZE-1 -: 4];
    assign w_dest   = instruction_in[11 -: REG_ADDR_SIZE];
    assign w_src1   = instruction_in[8 -: REG_ADDR_SIZE];
    assign w_src2   = instruction_in[5 -: REG_ADDR_SIZE];
    assign w_imm    = instruction_in[IMM_SIZE-1:0];

    // Per-class decode flags.
    logic w_reads_src1;
    logic w_reads_src2;
    logic w_reg_write;
    logic w_mem_read;
    logic w_mem_write;
    logic w_is_known;
    logic w_is_halt;

    // Registered stage outputs.
    logic [3:0]               r_opcode;
    logic [REG_ADDR_SIZE-1:0] r_dest;
    logic [REG_ADDR_SIZE-1:0] r_src1;
    logic [REG_ADDR_SIZE-1:0] r_src2;
    logic [IMM_SIZE-1:0]      r_imm;
    logic                     r_reg_write;
    logic                     r_mem_read;
    logic                     r_mem_write;

    logic w_hazard;
    logic w_load_fields;
    logic w_load_bubble;

    // Classify the opcode: which sources it reads and which side effects it has.
    always_comb begin
        w_reads_src1 = 1'b0;
        w_reads_src2 = 1'b0;
        w_reg_write  = 1'b0;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_is_known   = 1'b0;
        w_is_halt    = 1'b0;
        case (w_opcode)
            OP_NOP: begin
                w_is_known = 1'b1;
            end
            4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
                w_is_known   = 1'b1;
                w_reads_src1 = 1'b1;
                w_reads_src2 = 1'b1;
                w_reg_write  = 1'b1;
            end
            OP_LOAD: begin
                w_is_known   = 1'b1;
                w_reads_src1 = 1'b1;
                w_reg_write  = 1'b1;
                w_mem_read   = 1'b1;
            end
            OP_STORE: begin
                w_is_known   = 1'b1;
                w_reads_src1 = 1'b1;
                w_reads_src2 = 1'b1;
                w_mem_write  = 1'b1;
            end
            OP_LOADC: begin
                w_is_known  = 1'b1;
                w_reg_write = 1'b1;
            end
            OP_HALT: begin
                w_is_halt = 1'b1;
            end
            default: begin
                // Reserved opcodes fall through as bubbles.
            end
        endcase
    end

    // Load-use hazard: a LOAD sits in the output registers and the incoming
    // instruction reads its destination through a source it actually uses.
    assign w_hazard = (r_state == ST_RUN) && r_mem_read &&
                      ((w_reads_src1 && (w_src1 == r_dest)) ||
                       (w_reads_src2 && (w_src2 == r_dest)));

    assign halted        = (r_state == ST_HALTED);
    assign halt_or_stall = halted | w_hazard | stall_in;

    // FSM state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and output-register load selection, in priority order.
    always_comb begin
        w_state_next  = r_state;
        w_load_fields = 1'b0;
        w_load_bubble = 1'b0;
        if (!stall_in) begin
            case (r_state)
                ST_HALTED: begin
                    w_load_bubble = 1'b1;
                end
                ST_RUN: begin
                    if (w_hazard) begin
                        w_load_bubble = 1'b1;
                    end else if (w_is_halt) begin
                        w_load_bubble = 1'b1;
                        w_state_next  = ST_HALTED;
                    end else if (w_is_known) begin
                        w_load_fields = 1'b1;
                    end else begin
                        w_load_bubble = 1'b1;
                    end
                end
                default: begin
                    w_state_next = ST_RUN;
                end
            endcase
        end
    end

    // Output registers: load decoded fields, load a bubble, or hold.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_opcode    <= '0;
            r_dest      <= '0;
            r_src1      <= '0;
            r_src2      <= '0;
            r_imm       <= '0;
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
        end else if (w_load_fields) begin
            r_opcode    <= w_opcode;
            r_dest      <= w_dest;
            r_src1      <= w_src1;
            r_src2      <= w_src2;
            r_imm       <= w_imm;
            r_reg_write <= w_reg_write;
            r_mem_read  <= w_mem_read;
            r_mem_write <= w_mem_write;
        end else if (w_load_bubble) begin
            r_opcode    <= '0;
            r_dest      <= '0;
            r_src1      <= '0;
            r_src2      <= '0;
            r_imm       <= '0;
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
        end
    end

    assign opcode_out    = r_opcode;
    assign dest_out      = r_dest;
    assign src1_out      = r_src1;
    assign src2_out      = r_src2;
    assign imm_out       = r_imm;
    assign reg_write_out = r_reg_write;
    assign mem_read_out  = r_mem_read;
    assign mem_write_out = r_mem_write;

endmodule

// File: tb/tb_decode_unit.sv
// Bench for decode_unit: directed scenarios followed by randomized traffic.
// Every result is checked against an instruction-level reference model.
module tb_decode_unit;

  // ---------------- clock / reset ----------------
  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] instruction_in;
  logic        stall_in;
  logic        halt_or_stall;
  logic        halted;
  logic [3:0]  opcode_out;
  logic [2:0]  dest_out;
  logic [2:0]  src1_out;
  logic [2:0]  src2_out;
  logic [7:0]  imm_out;
  logic        reg_write_out;
  logic        mem_read_out;
  logic        mem_write_out;

  always #5 clock = ~clock;

  decode_unit dut (
    .clock          (clock),
    .reset          (reset),
    .instruction_in (instruction_in),
    .stall_in       (stall_in),
    .halt_or_stall  (halt_or_stall),
    .halted         (halted),
    .opcode_out     (opcode_out),
    .dest_out       (dest_out),
    .src1_out       (src1_out),
    .src2_out       (src2_out),
    .imm_out        (imm_out),
    .reg_write_out  (reg_write_out),
    .mem_read_out   (mem_read_out),
    .mem_write_out  (mem_write_out)
  );

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [3:0] op;
    logic [2:0] dest;
    logic [2:0] src1;
    logic [2:0] src2;
    logic [7:0] imm;
    logic       rw;
    logic       mr;
    logic       mw;
  } dec_t;

  dec_t m_out;
  logic m_halted;
  int   total = 0;
  int   bad   = 0;
  logic [31:0] exp_q[$];

  // What the stage should emit for an instruction accepted in RUN.
  function automatic dec_t model_decode(input logic [15:0] ins);
    dec_t d;
    d.op   = ins[15:12];
    d.dest = ins[11:9];
    d.src1 = ins[8:6];
    d.src2 = ins[5:3];
    d.imm  = ins[7:0];
    d.rw   = 1'b0;
    d.mr   = 1'b0;
    d.mw   = 1'b0;
    if (d.op >= 4'h1 && d.op <= 4'h7) d.rw = 1'b1;
    else if (d.op == 4'h8) begin d.rw = 1'b1; d.mr = 1'b1; end
    else if (d.op == 4'h9) d.mw = 1'b1;
    else if (d.op == 4'hA) d.rw = 1'b1;
    else if (d.op != 4'h0) d = '0;
    return d;
  endfunction

  // True when the instruction's class reads register r.
  function automatic logic model_reads(input logic [15:0] ins, input logic [2:0] r);
    logic [3:0] op;
    op = ins[15:12];
    if ((op >= 4'h1 && op <= 4'h7) || op == 4'h9)
      return (ins[8:6] == r) || (ins[5:3] == r);
    if (op == 4'h8)
      return ins[8:6] == r;
    return 1'b0;
  endfunction

  function automatic logic model_hazard(input logic [15:0] ins);
    return !m_halted && m_out.mr && model_reads(ins, m_out.dest);
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] dut_vec();
    return {7'b0, halted, opcode_out, dest_out, src1_out, src2_out, imm_out,
            reg_write_out, mem_read_out, mem_write_out};
  endfunction

  // ---------------- driver tasks ----------------
  // Entered at posedge+1. Presents one instruction for one cycle, checks the
  // combinational feedback, then checks the registered result after the edge.
  task automatic step(input logic [15:0] ins, input logic st, output logic accepted);
    logic hz;
    logic exp_hos;
    instruction_in = ins;
    stall_in       = st;
    #2;
    hz      = model_hazard(ins);
    exp_hos = m_halted | hz | st;
    check("halt_or_stall", {31'b0, halt_or_stall}, {31'b0, exp_hos});
    if (!st) begin
      if (m_halted || hz) m_out = '0;
      else if (ins[15:12] == 4'hF) begin
        m_out    = '0;
        m_halted = 1'b1;
      end else m_out = model_decode(ins);
    end
    exp_q.push_back({7'b0, m_halted, m_out});
    accepted = !exp_hos;
    @(posedge clock);
    #1;
    check("outputs", dut_vec(), exp_q.pop_front());
  endtask

  // Behaves like fetch: re-presents the instruction until it is consumed.
  task automatic issue(input logic [15:0] ins, output int tries);
    logic acc;
    acc   = 1'b0;
    tries = 0;
    while (!acc && tries < 6) begin
      step(ins, 1'b0, acc);
      tries++;
    end
    check("issue_accept", {31'b0, acc}, 32'd1);
  endtask

  // Asynchronous reset pulse applied away from the clock edge.
  task automatic do_reset();
    reset    = 1'b0;
    stall_in = 1'b0;
    #2;
    m_out    = '0;
    m_halted = 1'b0;
    check("reset_outputs", dut_vec(), 32'd0);
    check("reset_hos", {31'b0, halt_or_stall}, 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int          tries;
    logic        acc;
    logic [15:0] cur;
    logic [3:0]  op;
    logic [3:0]  ops[12];

    ops = '{4'h0, 4'h1, 4'h3, 4'h7, 4'h8, 4'h8, 4'h8, 4'h9, 4'hA, 4'hC, 4'hE, 4'hF};
    reset          = 1'b0;
    instruction_in = 16'h1252;
    stall_in       = 1'b0;
    m_out          = '0;
    m_halted       = 1'b0;
    @(posedge clock);
    #1;
    do_reset();

    // First decode after reset
    issue(16'h1252, tries);
    check("first_opcode", {28'b0, opcode_out}, 32'd1);
    check("first_src2", {29'b0, src2_out}, 32'd2);

    // Load-use: exactly one bubble
    issue(16'h8200, tries);
    issue(16'h1440, tries);
    check("loaduse_tries", tries, 2);
    check("loaduse_opcode", {28'b0, opcode_out}, 32'd1);

    // LOAD then LOADC to same register: no stall
    issue(16'h8200, tries);
    issue(16'hA2FF, tries);
    check("loadc_tries", tries, 1);
    check("loadc_imm", {24'b0, imm_out}, 32'hFF);

    // stall_in hold with STORE in the outputs
    issue(16'h9250, tries);
    for (int i = 0; i < 3; i++) step(16'h1252, 1'b1, acc);
    check("store_held_opcode", {28'b0, opcode_out}, 32'h9);
    issue(16'h1252, tries);
    check("after_stall_tries", tries, 1);

    // stall_in over a pending hazard, then one bubble
    issue(16'h8200, tries);
    step(16'h1440, 1'b1, acc);
    step(16'h1440, 1'b1, acc);
    issue(16'h1440, tries);
    check("stall_hazard_tries", tries, 2);

    // Reserved opcode after LOAD to a matching register
    issue(16'h8800, tries);
    issue(16'hC123, tries);
    check("reserved_tries", tries, 1);

    // HALT is sticky until reset
    issue(16'hF000, tries);
    check("halt_tries", tries, 1);
    for (int i = 0; i < 3; i++) step(16'h1252, 1'b0, acc);
    check("halted_flag", {31'b0, halted}, 32'd1);
    do_reset();
    issue(16'h1252, tries);

    // Randomized traffic with stalls, halts and mid-run resets
    cur = 16'h0000;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 59) == 0 || (m_halted && $urandom_range(0, 3) == 0)) begin
        do_reset();
      end else begin
        step(cur, ($urandom_range(0, 4) == 0), acc);
        if (acc) begin
          op = ops[$urandom_range(0, 11)];
          if (op == 4'h0) cur = 16'h0000;
          else cur = {op, 12'($urandom)} & 16'hF6DF;
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog against a stuck simulation.
  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
